serial_mag_compare_ctrl: RTL and testbench

SERIAL_MAG_COMPARE_CTRL -- requirements
Module: serial_mag_compare_ctrl

---
 rtl/serial_mag_compare_ctrl_pkg.sv | 14 +
 rtl/serial_mag_compare_ctrl_cmp2_slice.sv | 16 +
 rtl/serial_mag_compare_ctrl.sv | 90 +++++++++
 tb/tb_serial_mag_compare_ctrl.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/serial_mag_compare_ctrl_pkg.sv
// serial_mag_compare_ctrl_pkg: shared state type and pair/steps width helpers
package serial_mag_compare_ctrl_pkg;

    typedef enum logic {IDLE, RUN} state_t;

    function automatic int pairs(input int width);
        return width / 2;
    endfunction

    function automatic int steps_w(input int width);
        return $clog2(width / 2) + 1;
    endfunction

endpackage

// File: rtl/serial_mag_compare_ctrl_cmp2_slice.sv
// cmp2_slice: magnitude compare of one 2-bit pair
module cmp2_slice (
    input  logic a1,
    input  logic a0,
    input  logic b1,
    input  logic b0,
    output logic gt,
    output logic eq,
    output logic lt
);

    assign gt = {a1, a0} > {b1, b0};
    assign eq = {a1, a0} == {b1, b0};
    assign lt = {a1, a0} < {b1, b0};

endmodule

// File: rtl/serial_mag_compare_ctrl.sv
// serial_mag_compare_ctrl: MSB-first 2-bit-per-cycle magnitude comparator with early exit
module serial_mag_compare_ctrl
    import serial_mag_compare_ctrl_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        start,
    input  logic [WIDTH-1:0]            a,
    input  logic [WIDTH-1:0]            b,
    output logic                        busy,
    output logic                        done,
    output logic                        g,
    output logic                        e,
    output logic                        l,
    output logic [steps_w(WIDTH)-1:0]   steps
);

    localparam int SW = steps_w(WIDTH);
    localparam int NP = pairs(WIDTH);

    state_t state, state_nx;
    logic [WIDTH-1:0] ra, rb;
    logic [SW-1:0] cnt;
    logic gt, eq, lt, load, last, fin;

    // the operands shift left each cycle so the pair under test is always the top two bits
    cmp2_slice u_slice (
        .a1 (ra[WIDTH-1]),
        .a0 (ra[WIDTH-2]),
        .b1 (rb[WIDTH-1]),
        .b0 (rb[WIDTH-2]),
        .gt (gt),
        .eq (eq),
        .lt (lt)
    );

    // state register
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    // next state: leave RUN on the first unequal pair or after the last pair
    always_comb begin
        state_nx = state == IDLE ? (start ? RUN : IDLE) : (fin ? IDLE : RUN);
    end

    // status and control strobes
    always_comb begin
        busy = state == RUN;
        load = state == IDLE && start;
        last = cnt == SW'(NP - 1);
        fin  = busy && (!eq || last);
    end

    // operand capture, pair stepping and result registers
    always_ff @(posedge clk) begin
        if (rst) begin
            done  <= 1'b0;
            g     <= 1'b0;
            e     <= 1'b0;
            l     <= 1'b0;
            steps <= '0;
            cnt   <= '0;
            ra    <= '0;
            rb    <= '0;
        end else begin
            done <= fin;
            if (load) begin
                ra  <= a;
                rb  <= b;
                cnt <= '0;
            end
            if (busy) begin
                ra  <= ra << 2;
                rb  <= rb << 2;
                cnt <= cnt + SW'(1);
            end
            if (fin) begin
                g     <= gt;
                e     <= eq;
                l     <= lt;
                steps <= cnt + SW'(1);
            end
        end
    end

endmodule

// File: tb/tb_serial_mag_compare_ctrl.sv
// tb_serial_mag_compare_ctrl: randomized and directed checks against an arithmetic reference
module tb_serial_mag_compare_ctrl;
    import serial_mag_compare_ctrl_pkg::*;

    logic clk = 1'b0;
    logic rst;
    logic start8, busy8, done8, g8, e8, l8;
    logic [7:0] a8, b8;
    logic [steps_w(8)-1:0] steps8;
    logic start4, busy4, done4, g4, e4, l4;
    logic [3:0] a4, b4;
    logic [steps_w(4)-1:0] steps4;

    int n_cmp = 0;
    int n_bad = 0;
    int m_gel[2];
    int m_steps[2];

    always #5 clk = ~clk;

    serial_mag_compare_ctrl #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8),
        .busy(busy8), .done(done8), .g(g8), .e(e8), .l(l8), .steps(steps8)
    );

    serial_mag_compare_ctrl #(.WIDTH(4)) dut4 (
        .clk(clk), .rst(rst), .start(start4), .a(a4), .b(b4),
        .busy(busy4), .done(done4), .g(g4), .e(e4), .l(l4), .steps(steps4)
    );

    task automatic check(input string tag, input int got, input int exp);
        n_cmp++;
        if (got != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // number of MSB-first pairs inspected before a decision
    function automatic int ref_steps(input int w, input int x, input int y);
        for (int k = 1; k <= w / 2; k++)
            if (((x >> (w - 2 * k)) & 3) != ((y >> (w - 2 * k)) & 3)) return k;
        return w / 2;
    endfunction

    // {g,e,l} as a 3-bit code
    function automatic int ref_gel(input int x, input int y);
        return x > y ? 4 : (x == y ? 2 : 1);
    endfunction

    function automatic int dn(input int w);
        return w == 8 ? int'(done8) : int'(done4);
    endfunction

    function automatic int bz(input int w);
        return w == 8 ? int'(busy8) : int'(busy4);
    endfunction

    function automatic int gel(input int w);
        return w == 8 ? int'({g8, e8, l8}) : int'({g4, e4, l4});
    endfunction

    function automatic int st(input int w);
        return w == 8 ? int'(steps8) : int'(steps4);
    endfunction

    task automatic drive(input int w, input logic s, input int x, input int y);
        if (w == 8) begin
            start8 = s; a8 = 8'(x); b8 = 8'(y);
        end else begin
            start4 = s; a4 = 4'(x); b4 = 4'(y);
        end
    endtask

    // one compare; entered and left at a falling edge
    task automatic cmp(input int w, input int x, input int y);
        int k, exp_k, i;
        i = w == 8 ? 0 : 1;
        exp_k = ref_steps(w, x, y);
        drive(w, 1'b1, x, y);
        @(posedge clk);
        @(negedge clk);
        drive(w, 1'b0, $urandom, $urandom);
        check("busy_run", bz(w), 1);
        check("done_early", dn(w), 0);
        check("gel_hold", gel(w), m_gel[i]);
        check("steps_hold", st(w), m_steps[i]);
        k = 0;
        while (!dn(w) && k < w) begin
            @(posedge clk);
            k++;
            @(negedge clk);
        end
        m_gel[i] = ref_gel(x, y);
        m_steps[i] = exp_k;
        check("latency", k, exp_k);
        check("gel", gel(w), m_gel[i]);
        check("steps", st(w), exp_k);
        check("busy_done", bz(w), 0);
        @(negedge clk);
        check("done_fall", dn(w), 0);
    endtask

    initial begin
        int x, y, nd, at;
        rst = 1'b1;
        drive(8, 1'b0, 0, 0);
        drive(4, 1'b0, 0, 0);
        m_gel = '{0, 0};
        m_steps = '{0, 0};
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        check("rst_busy", int'(busy8), 0);
        check("rst_done", int'(done8), 0);
        check("rst_gel", int'({g8, e8, l8}), 0);
        check("rst_steps", int'(steps8), 0);
        check("rst_gel4", int'({g4, e4, l4}), 0);

        cmp(8, 'hC0, 'h40);
        check("c0_steps", int'(steps8), 1);
        check("c0_g", int'(g8), 1);
        cmp(8, 'h5A, 'h5A);
        check("5a_e", int'(e8), 1);
        cmp(8, 'h12, 'h13);
        check("12_l", int'(l8), 1);
        check("12_steps", int'(steps8), 4);
        cmp(8, 'h1F, 'h13);
        check("1f_steps", int'(steps8), 3);

        // starts at E1 and E2 with new operands must be ignored
        drive(8, 1'b1, 'h5A, 'h5A);
        @(posedge clk);
        @(negedge clk);
        drive(8, 1'b1, 'h00, 'hFF);
        @(posedge clk);
        @(negedge clk);
        @(posedge clk);
        @(negedge clk);
        drive(8, 1'b0, 'hFF, 'h00);
        nd = 0;
        at = 0;
        for (int i = 3; i <= 9; i++) begin
            @(posedge clk);
            @(negedge clk);
            if (done8) begin
                nd++;
                at = i;
            end
        end
        check("ign_ndone", nd, 1);
        check("ign_edge", at, 4);
        check("ign_gel", int'({g8, e8, l8}), 2);
        check("ign_steps", int'(steps8), 4);
        m_gel[0] = 2;
        m_steps[0] = 4;

        // reset at E2 aborts the compare
        drive(8, 1'b1, 'h12, 'h13);
        @(posedge clk);
        @(negedge clk);
        drive(8, 1'b0, 0, 0);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        m_gel[0] = 0;
        m_steps[0] = 0;
        check("abort_busy", int'(busy8), 0);
        check("abort_done", int'(done8), 0);
        check("abort_gel", int'({g8, e8, l8}), 0);
        check("abort_steps", int'(steps8), 0);
        cmp(8, 'h1F, 'h13);

        // start held high: a new result every second cycle
        drive(8, 1'b1, 'hFF, 'h00);
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            @(negedge clk);
            check("hold_done", int'(done8), i % 2);
            if (i > 0) check("hold_g", int'(g8), 1);
        end
        drive(8, 1'b0, 0, 0);
        repeat (2) @(negedge clk);
        m_gel[0] = 4;
        m_steps[0] = 1;

        repeat (150) begin
            x = int'($urandom_range(0, 255));
            case ($urandom_range(0, 2))
                0: y = int'($urandom_range(0, 255));
                1: y = x ^ (1 << $urandom_range(0, 7));
                default: y = x;
            endcase
            cmp(8, x, y);
        end

        for (int p = 0; p < 16; p++)
            for (int q = 0; q < 16; q++)
                cmp(4, p, q);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
